// File: rtl/vs1003_pkg.sv
// Shared constants for the VS1003 serial-interface responder: SCI opcodes,
// register addresses, reset values and frame lengths.
package vs1003_pkg;

  localparam logic [7:0]  OP_WRITE       = 8'h02;
  localparam logic [7:0]  OP_READ        = 8'h03;

  localparam logic [7:0]  ADDR_MODE      = 8'h00;
  localparam logic [7:0]  ADDR_VOL       = 8'h0B;

  localparam logic [15:0] MODE_RESET_VAL = 16'h0800;
  localparam int          SM_RESET_BIT   = 2;

  localparam int          SCI_FRAME_BITS = 32;
  localparam int          SDI_FRAME_BITS = 16;

  // MODE value as stored: the soft-reset request bit never sticks.
  function automatic logic [15:0] mode_store(input logic [15:0] data);
    logic [15:0] v;
    v = data;
    v[SM_RESET_BIT] = 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/vs1003_spi_responder_sync_fifo.sv
// First-word fall-through FIFO for SDI audio words, with synchronous flush and
// occupancy output. A push while full is dropped unless a pop happens in the
// same cycle, in which case both succeed.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_temp,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          valid,
  output logic          full,
  output logic [AW:0]   occupancy
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign valid     = (count != '0);
  assign full      = (count == DEPTH_C);
  assign occupancy = count;
  assign do_pop    = pop & valid;
  assign do_push   = push & (~full | do_pop);
  assign dout      = valid ? mem[rd_ptr] : '0;

  // Storage array: written on every accepted push, never reset.
  always_ff @(posedge clk_temp) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; flush empties the FIFO in one cycle.
  always_ff @(posedge clk_temp or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vs1003_spi_responder.sv
// Slave-side VS1003 serial interface: synchronizes the pin inputs, decodes SCI
// command frames and SDI data words, holds MODE/VOL, buffers audio words and
// drives DREQ flow control.
//
// Consumer handshake: o_word is valid whenever o_word_valid is high; a word is
// removed on every clk_temp edge where o_word_valid and i_word_ready are both
// high. o_word_valid never drops without a pop, flush, or reset.
module vs1003_spi_responder
  import vs1003_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DREQ_SLACK = 2,
  parameter int SCI_BUSY   = 32,
  parameter int RESET_BUSY = 64
) (
  input  logic        clk_temp,
  input  logic        rst_n,
  input  logic        i_XRST,
  input  logic        i_XCS,
  input  logic        i_XDCS,
  input  logic        i_SCK,
  input  logic        i_SI,
  output logic        o_DREQ,
  output logic [15:0] o_mode,
  output logic [15:0] o_vol,
  output logic        o_sci_wr,
  output logic [15:0] o_word,
  output logic        o_word_valid,
  input  logic        i_word_ready,
  output logic [15:0] o_sdi_count,
  output logic        o_err
);

  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int BUSY_MAX = (RESET_BUSY > SCI_BUSY) ? RESET_BUSY : SCI_BUSY;
  localparam int BW       = $clog2(BUSY_MAX + 1);
  localparam logic [BW-1:0] BUSY_RESET = BW'(RESET_BUSY);
  localparam logic [BW-1:0] BUSY_SCI   = BW'(SCI_BUSY);
  localparam logic [AW:0]   DREQ_LIMIT = (AW+1)'(FIFO_DEPTH - DREQ_SLACK);
  localparam logic [4:0]    SCI_LAST   = 5'(SCI_FRAME_BITS - 1);
  localparam logic [3:0]    SDI_LAST   = 4'(SDI_FRAME_BITS - 1);

  // Synchronizer stages; selects and XRST rest inactive-high.
  logic [1:0] xrst_sync, xcs_sync, xdcs_sync, sck_sync, si_sync;
  logic       sck_prev;

  logic       xrst_low, xcs_low, xdcs_low, sck_rise, si_bit;

  logic [31:0] sci_sh;
  logic [4:0]  sci_cnt;
  logic        sci_done;
  logic [15:0] sdi_sh;
  logic [3:0]  sdi_cnt;
  logic        sdi_done;

  logic [7:0]  sci_op, sci_addr;
  logic [15:0] sci_data;
  logic        sci_write, mode_hit, vol_hit, soft_reset;

  logic [BW-1:0] busy;
  logic          fifo_full;
  logic [AW:0]   fifo_occ;
  logic          pop_ok, push_ok, fifo_flush;
  logic          err_event;

  assign xrst_low = ~xrst_sync[1];
  assign xcs_low  = ~xcs_sync[1];
  assign xdcs_low = ~xdcs_sync[1];
  assign sck_rise = sck_sync[1] & ~sck_prev;
  assign si_bit   = si_sync[1];

  assign sci_op     = sci_sh[31:24];
  assign sci_addr   = sci_sh[23:16];
  assign sci_data   = sci_sh[15:0];
  assign sci_write  = sci_done & (sci_op == OP_WRITE);
  assign mode_hit   = sci_write & (sci_addr == ADDR_MODE);
  assign vol_hit    = sci_write & (sci_addr == ADDR_VOL);
  assign soft_reset = mode_hit & sci_data[SM_RESET_BIT];

  assign pop_ok     = o_word_valid & i_word_ready;
  assign push_ok    = sdi_done & (~fifo_full | pop_ok);
  assign fifo_flush = soft_reset | xrst_low;

  assign err_event = ~xrst_low & (
      (sck_rise & xcs_low & xdcs_low)
    | (~xcs_low & (sci_cnt != '0))
    | (~xdcs_low & (sdi_cnt != '0))
    | (sci_done & (sci_op != OP_WRITE))
    | (sdi_done & fifo_full & ~pop_ok));

  // Two-flop synchronizers for all pin inputs plus SCK edge history.
  always_ff @(posedge clk_temp or negedge rst_n) begin
    if (!rst_n) begin
      xrst_sync <= 2'b11;
      xcs_sync  <= 2'b11;
      xdcs_sync <= 2'b11;
      sck_sync  <= 2'b00;
      si_sync   <= 2'b00;
      sck_prev  <= 1'b0;
    end else begin
      xrst_sync <= {xrst_sync[0], i_XRST};
      xcs_sync  <= {xcs_sync[0], i_XCS};
      xdcs_sync <= {xdcs_sync[0], i_XDCS};
      sck_sync  <= {sck_sync[0], i_SCK};
      si_sync   <= {si_sync[0], i_SI};
      sck_prev  <= sck_sync[1];
    end
  end

  // SCI and SDI shifters with bit counters; frame-complete flags fire one
  // cycle after the last bit lands.
  always_ff @(posedge clk_temp or negedge rst_n) begin
    if (!rst_n) begin
      sci_sh   <= '0;
      sci_cnt  <= '0;
      sci_done <= 1'b0;
      sdi_sh   <= '0;
      sdi_cnt  <= '0;
      sdi_done <= 1'b0;
    end else if (xrst_low) begin
      sci_sh   <= '0;
      sci_cnt  <= '0;
      sci_done <= 1'b0;
      sdi_sh   <= '0;
      sdi_cnt  <= '0;
      sdi_done <= 1'b0;
    end else begin
      sci_done <= 1'b0;
      sdi_done <= 1'b0;
      if (sck_rise && xcs_low && !xdcs_low) begin
        sci_sh  <= {sci_sh[30:0], si_bit};
        sci_cnt <= (sci_cnt == SCI_LAST) ? '0 : sci_cnt + 1'b1;
        if (sci_cnt == SCI_LAST) sci_done <= 1'b1;
      end else if (!xcs_low && sci_cnt != '0) begin
        sci_cnt <= '0;
      end
      if (sck_rise && xdcs_low && !xcs_low) begin
        sdi_sh  <= {sdi_sh[14:0], si_bit};
        sdi_cnt <= (sdi_cnt == SDI_LAST) ? '0 : sdi_cnt + 1'b1;
        if (sdi_cnt == SDI_LAST) sdi_done <= 1'b1;
      end else if (!xdcs_low && sdi_cnt != '0) begin
        sdi_cnt <= '0;
      end
      if (soft_reset) sdi_cnt <= '0;
    end
  end

  // Architectural registers, write strobe and accepted-word counter.
  always_ff @(posedge clk_temp or negedge rst_n) begin
    if (!rst_n) begin
      o_mode      <= MODE_RESET_VAL;
      o_vol       <= '0;
      o_sci_wr    <= 1'b0;
      o_sdi_count <= '0;
    end else if (xrst_low) begin
      o_mode      <= MODE_RESET_VAL;
      o_vol       <= '0;
      o_sci_wr    <= 1'b0;
      o_sdi_count <= '0;
    end else begin
      o_sci_wr <= sci_write;
      if (mode_hit) o_mode <= mode_store(sci_data);
      if (vol_hit)  o_vol  <= sci_data;
      if (soft_reset)   o_sdi_count <= '0;
      else if (push_ok) o_sdi_count <= o_sdi_count + 1'b1;
    end
  end

  // Busy counter: reset-class events win over an ordinary SCI write.
  always_ff @(posedge clk_temp or negedge rst_n) begin
    if (!rst_n)               busy <= BUSY_RESET;
    else if (xrst_low)        busy <= BUSY_RESET;
    else if (soft_reset)      busy <= BUSY_RESET;
    else if (sci_write)       busy <= BUSY_SCI;
    else if (busy != '0)      busy <= busy - 1'b1;
  end

  // Registered DREQ from reset, busy and FIFO occupancy.
  always_ff @(posedge clk_temp or negedge rst_n) begin
    if (!rst_n) o_DREQ <= 1'b0;
    else        o_DREQ <= ~xrst_low & (busy == '0) & (fifo_occ < DREQ_LIMIT);
  end

  // Sticky protocol error; only rst_n clears it.
  always_ff @(posedge clk_temp or negedge rst_n) begin
    if (!rst_n)         o_err <= 1'b0;
    else if (err_event) o_err <= 1'b1;
  end

  sync_fifo #(.DEPTH(FIFO_DEPTH), .W(16)) u_fifo (
    .clk_temp  (clk_temp),
    .rst_n     (rst_n),
    .flush     (fifo_flush),
    .push      (sdi_done),
    .din       (sdi_sh),
    .pop       (i_word_ready),
    .dout      (o_word),
    .valid     (o_word_valid),
    .full      (fifo_full),
    .occupancy (fifo_occ)
  );

endmodule

// File: tb/tb_vs1003_spi_responder.sv
// Directed bench for vs1003_spi_responder: register writes, soft and hardware
// reset, SDI streaming, FIFO overflow and protocol error cases.
module tb_vs1003_spi_responder;

  logic        clk_temp = 1'b0;
  logic        rst_n    = 1'b0;
  logic        i_XRST   = 1'b1;
  logic        i_XCS    = 1'b1;
  logic        i_XDCS   = 1'b1;
  logic        i_SCK    = 1'b0;
  logic        i_SI     = 1'b0;
  logic        i_word_ready = 1'b0;
  logic        o_DREQ;
  logic [15:0] o_mode, o_vol, o_word, o_sdi_count;
  logic        o_sci_wr, o_word_valid, o_err;

  int checks   = 0;
  int failures = 0;

  // monitor state (written only by the monitor process)
  int          wr_cnt  = 0;
  int          low_cnt = 0;
  logic [15:0] got_q[$];
  // expected consumer words
  logic [15:0] exp_q[$];

  vs1003_spi_responder dut (
    .clk_temp     (clk_temp),
    .rst_n        (rst_n),
    .i_XRST       (i_XRST),
    .i_XCS        (i_XCS),
    .i_XDCS       (i_XDCS),
    .i_SCK        (i_SCK),
    .i_SI         (i_SI),
    .o_DREQ       (o_DREQ),
    .o_mode       (o_mode),
    .o_vol        (o_vol),
    .o_sci_wr     (o_sci_wr),
    .o_word       (o_word),
    .o_word_valid (o_word_valid),
    .i_word_ready (i_word_ready),
    .o_sdi_count  (o_sdi_count),
    .o_err        (o_err)
  );

  // clock
  always #5 clk_temp = ~clk_temp;

  // monitor: write pulses, DREQ-low cycles, consumed words
  always @(negedge clk_temp) begin
    if (o_sci_wr) wr_cnt++;
    if (!o_DREQ) low_cnt++;
    if (o_word_valid && i_word_ready) got_q.push_back(o_word);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_temp);
  endtask

  task automatic wait_dreq(input string tag);
    int n;
    n = 0;
    while (!o_DREQ && n < 1000) begin
      @(negedge clk_temp);
      n++;
    end
    check(tag, {31'd0, o_DREQ}, 32'd1);
  endtask

  // rst_n pulse; returns with DREQ high, reports release-to-DREQ latency
  task automatic do_reset(input string tag);
    int n;
    i_XRST = 1'b1; i_XCS = 1'b1; i_XDCS = 1'b1; i_SCK = 1'b0; i_SI = 1'b0;
    i_word_ready = 1'b0;
    rst_n = 1'b0;
    cycles(4);
    rst_n = 1'b1;
    n = 0;
    while (!o_DREQ && n < 200) begin
      @(negedge clk_temp);
      n++;
    end
    check(tag, n, 65);
  endtask

  task automatic spi_bit(input logic b);
    i_SI = b;
    cycles(5);
    i_SCK = 1'b1;
    cycles(5);
    i_SCK = 1'b0;
  endtask

  task automatic sci_frame(input logic [31:0] f);
    i_XCS = 1'b0;
    cycles(5);
    for (int i = 31; i >= 0; i--) spi_bit(f[i]);
    cycles(5);
    i_XCS = 1'b1;
    cycles(10);
  endtask

  task automatic sdi_bits(input logic [15:0] w, input int nbits);
    i_XDCS = 1'b0;
    cycles(5);
    for (int i = 15; i > 15 - nbits; i--) spi_bit(w[i]);
    cycles(5);
    i_XDCS = 1'b1;
    cycles(10);
  endtask

  initial begin
    int l0, w0, g0;

    // ---- power-on reset ----
    do_reset("reset_dreq_latency");
    check("reset_mode", o_mode, 32'h0800);
    check("reset_vol", o_vol, 32'h0000);
    check("reset_valid", o_word_valid, 32'd0);
    check("reset_word", o_word, 32'h0000);
    check("reset_count", o_sdi_count, 32'd0);
    check("reset_err", o_err, 32'd0);

    // ---- VOL write ----
    l0 = low_cnt; w0 = wr_cnt;
    sci_frame(32'h020B2020);
    cycles(60);
    check("vol_value", o_vol, 32'h2020);
    check("vol_wr_pulses", wr_cnt - w0, 32'd1);
    check("vol_dreq_low", low_cnt - l0, 32'd32);
    check("vol_err", o_err, 32'd0);

    // ---- MODE write without soft reset ----
    wait_dreq("dreq_before_mode");
    sci_frame(32'h02004810);
    cycles(5);
    check("mode_value", o_mode, 32'h4810);

    // ---- buffered words then soft reset ----
    wait_dreq("dreq_before_sdi");
    sdi_bits(16'h1234, 16);
    sdi_bits(16'hABCD, 16);
    check("preload_count", o_sdi_count, 32'd2);
    check("preload_head", o_word, 32'h1234);
    check("preload_valid", o_word_valid, 32'd1);
    l0 = low_cnt; w0 = wr_cnt;
    sci_frame(32'h02000804);
    cycles(100);
    check("softrst_mode", o_mode, 32'h0800);
    check("softrst_valid", o_word_valid, 32'd0);
    check("softrst_count", o_sdi_count, 32'd0);
    check("softrst_dreq_low", low_cnt - l0, 32'd64);
    check("softrst_wr_pulses", wr_cnt - w0, 32'd1);

    // ---- streaming with a ready consumer ----
    wait_dreq("dreq_before_stream");
    i_word_ready = 1'b1;
    g0 = got_q.size();
    exp_q.push_back(16'h1234);
    exp_q.push_back(16'hABCD);
    sdi_bits(16'h1234, 16);
    sdi_bits(16'hABCD, 16);
    cycles(10);
    check("stream_got_n", got_q.size() - g0, 32'd2);
    for (int i = 0; i < 2; i++)
      if (g0 + i < got_q.size()) check("stream_word", got_q[g0 + i], exp_q[i]);
    check("stream_count", o_sdi_count, 32'd2);
    check("stream_valid", o_word_valid, 32'd0);

    // ---- stalled consumer, fill and overflow ----
    i_word_ready = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 13; k++) begin
      exp_q.push_back(16'h1000 + 16'(k));
      sdi_bits(16'h1000 + 16'(k), 16);
    end
    check("occ13_dreq", o_DREQ, 32'd1);
    exp_q.push_back(16'h100D);
    sdi_bits(16'h100D, 16);
    check("occ14_dreq", o_DREQ, 32'd0);
    exp_q.push_back(16'h100E);
    sdi_bits(16'h100E, 16);
    exp_q.push_back(16'h100F);
    sdi_bits(16'h100F, 16);
    check("full_err", o_err, 32'd0);
    check("full_count", o_sdi_count, 32'd18);
    sdi_bits(16'hDEAD, 16);
    check("overflow_err", o_err, 32'd1);
    check("overflow_count", o_sdi_count, 32'd18);
    g0 = got_q.size();
    i_word_ready = 1'b1;
    cycles(40);
    check("drain_got_n", got_q.size() - g0, 32'd16);
    for (int i = 0; i < 16; i++)
      if (g0 + i < got_q.size()) check("drain_word", got_q[g0 + i], exp_q[i]);
    check("drain_dreq", o_DREQ, 32'd1);

    // ---- partial SDI frame ----
    do_reset("reset2_dreq_latency");
    sdi_bits(16'hFE00, 7);
    check("partial_err", o_err, 32'd1);
    check("partial_count", o_sdi_count, 32'd0);
    check("partial_valid", o_word_valid, 32'd0);
    sdi_bits(16'h5A5A, 16);
    check("after_partial_count", o_sdi_count, 32'd1);
    check("after_partial_word", o_word, 32'h5A5A);

    // ---- hardware XRST: registers reset, error kept ----
    wait_dreq("dreq_before_xrst");
    sci_frame(32'h020B1111);
    cycles(5);
    check("pre_xrst_vol", o_vol, 32'h1111);
    i_XRST = 1'b0;
    cycles(10);
    check("xrst_dreq", o_DREQ, 32'd0);
    i_XRST = 1'b1;
    cycles(5);
    check("xrst_vol", o_vol, 32'h0000);
    check("xrst_mode", o_mode, 32'h0800);
    check("xrst_count", o_sdi_count, 32'd0);
    check("xrst_valid", o_word_valid, 32'd0);
    check("xrst_err_kept", o_err, 32'd1);
    cycles(30);
    check("xrst_busy_dreq", o_DREQ, 32'd0);
    wait_dreq("dreq_after_xrst");

    // ---- unsupported opcode ----
    do_reset("reset3_dreq_latency");
    w0 = wr_cnt;
    sci_frame(32'h030B1111);
    cycles(5);
    check("badop_vol", o_vol, 32'h0000);
    check("badop_err", o_err, 32'd1);
    check("badop_wr_pulses", wr_cnt - w0, 32'd0);

    // ---- both selects low on an SCK edge ----
    do_reset("reset4_dreq_latency");
    i_XCS = 1'b0;
    i_XDCS = 1'b0;
    cycles(5);
    spi_bit(1'b1);
    cycles(5);
    i_XCS = 1'b1;
    i_XDCS = 1'b1;
    cycles(10);
    check("both_sel_err", o_err, 32'd1);
    check("both_sel_count", o_sdi_count, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
